// File: rtl/fb_write_arbiter_pkg.sv
// Shared types and defaults for the framebuffer write-port arbiter.
package fb_write_arbiter_pkg;

    localparam int unsigned FB_ADDR_W = 9;
    localparam int unsigned FB_DATA_W = 8;

    // CPU four-phase handshake states
    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_ACK  = 2'd1,
        H_DROP = 2'd2
    } hs_state_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Renderer strobe, CPU handshake and framebuffer write-port bundle.
interface fb_write_arbiter_if #(
    parameter int unsigned ADDR_W = fb_write_arbiter_pkg::FB_ADDR_W,
    parameter int unsigned DATA_W = fb_write_arbiter_pkg::FB_DATA_W
) ();

    logic              panel_wen;
    logic [ADDR_W-1:0] panel_A;
    logic [DATA_W-1:0] panel_D;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_A;
    logic [DATA_W-1:0] cpu_D;
    logic              cpu_ack;

    logic              fbw_en;
    logic [ADDR_W-1:0] fbw_A;
    logic [DATA_W-1:0] fbw_D;

    // Upstream side: renderer, CPU bridge, and observer of the write port
    modport master (
        output panel_wen, panel_A, panel_D, cpu_req, cpu_A, cpu_D,
        input  cpu_ack, fbw_en, fbw_A, fbw_D
    );

    // Arbiter side
    modport slave (
        input  panel_wen, panel_A, panel_D, cpu_req, cpu_A, cpu_D,
        output cpu_ack, fbw_en, fbw_A, fbw_D
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering CPU framebuffer writes.
module fb_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow regardless of caller behaviour
    always_comb begin
        do_push = push && (count != CNT_W'(DEPTH));
        do_pop  = pop && (count != '0);
    end

    assign head_data_c = mem[rd_ptr];

    // Storage needs no reset; stale entries are never read past count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: renderer always wins, CPU writes are
// buffered and drained into idle (optionally blanking-only) cycles.
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = FB_ADDR_W,
    parameter int unsigned DATA_W       = FB_DATA_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          BLANK_ONLY   = 1'b1,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic                          clk_vga,
    input  logic                          rst,
    input  logic                          blank,
    fb_write_arbiter_if.slave             bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          starve
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    hs_state_e            state_q;
    hs_state_e            state_d;
    logic                 ack_d;
    logic                 full_c;
    logic                 push_c;
    logic                 pop_c;
    logic [ENTRY_W-1:0]   head_c;
    logic [STARVE_W-1:0]  starve_cnt_q;
    logic [STARVE_W-1:0]  starve_cnt_d;
    logic                 starve_d;

    // Capture and drain qualifiers; full uses the count before this cycle's pop
    always_comb begin
        full_c = (fifo_count == CNT_W'(FIFO_DEPTH));
        push_c = (state_q == H_IDLE) && bus.cpu_req && !full_c;
        pop_c  = !bus.panel_wen && (fifo_count != '0) && (blank || !BLANK_ONLY);
    end

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk_vga),
        .rst         (rst),
        .push        (push_c),
        .push_data   ({bus.cpu_A, bus.cpu_D}),
        .pop         (pop_c),
        .head_data_c (head_c),
        .count       (fifo_count)
    );

    // Handshake next-state; ack mirrors the registered H_ACK state
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        case (state_q)
            H_IDLE: if (push_c) state_d = H_ACK;
            H_ACK:  if (!bus.cpu_req) state_d = H_DROP;
            H_DROP: state_d = H_IDLE;
            default: state_d = H_IDLE;
        endcase
        ack_d = (state_d == H_ACK);
    end

    // Handshake state and acknowledge registers
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_q     <= H_IDLE;
            bus.cpu_ack <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus.cpu_ack <= ack_d;
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            bus.fbw_en <= 1'b0;
            bus.fbw_A  <= '0;
            bus.fbw_D  <= '0;
        end else if (bus.panel_wen) begin
            bus.fbw_en <= 1'b1;
            bus.fbw_A  <= bus.panel_A;
            bus.fbw_D  <= bus.panel_D;
        end else if (pop_c) begin
            bus.fbw_en <= 1'b1;
            bus.fbw_A  <= head_c[ENTRY_W-1:DATA_W];
            bus.fbw_D  <= head_c[DATA_W-1:0];
        end else begin
            bus.fbw_en <= 1'b0;
        end
    end

    // Saturating starvation counter: counts full-and-blocked cycles
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop_c) begin
            starve_cnt_d = '0;
        end else if (full_c && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
        starve_d = starve || (starve_cnt_d == STARVE_W'(STARVE_LIMIT));
    end

    // Counter and sticky starvation flag
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            starve       <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve       <= starve_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter (table vectors plus sequences).
module tb_fb_write_arbiter;

    logic       clk_vga;
    logic       rst;
    logic       blank;
    logic [2:0] fifo_count;
    logic       starve;

    int errors = 0;
    int checks = 0;

    fb_write_arbiter_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    fb_write_arbiter #(
        .ADDR_W       (9),
        .DATA_W       (8),
        .FIFO_DEPTH   (4),
        .BLANK_ONLY   (1'b1),
        .STARVE_LIMIT (8)
    ) dut (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .blank      (blank),
        .bus        (bus),
        .fifo_count (fifo_count),
        .starve     (starve)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    typedef struct {
        logic       pw;
        logic [8:0] pa;
        logic [7:0] pd;
        logic       req;
        logic [8:0] ca;
        logic [7:0] cd;
        logic       blk;
        logic       e_en;
        logic [8:0] e_a;
        logic [7:0] e_d;
        logic       e_ack;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full four-phase CPU write with bounded waits on ack
    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        int n;
        bus.cpu_A   = a;
        bus.cpu_D   = d;
        bus.cpu_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.cpu_ack && n < 20);
        check("cpu_write ack rise", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.cpu_ack && n < 20);
        check("cpu_write ack fall", 32'(bus.cpu_ack), 32'd0);
    endtask

    initial begin
        logic [8:0] ea [5];
        logic [7:0] ed [5];
        logic [2:0] ecnt [5];
        int n;

        //            pw   pa      pd     req  ca      cd     blk  en   A       D      ack  cnt
        vecs[0]  = '{1'b1, 9'h012, 8'h41, 1'b0, 9'h000, 8'h00, 1'b0, 1'b1, 9'h012, 8'h41, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 9'h012, 8'h41, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 9'h000, 8'h00, 1'b1, 9'h100, 8'h5A, 1'b1, 1'b0, 9'h012, 8'h41, 1'b1, 3'd1};
        vecs[3]  = '{1'b0, 9'h000, 8'h00, 1'b1, 9'h100, 8'h5A, 1'b1, 1'b1, 9'h100, 8'h5A, 1'b1, 3'd0};
        vecs[4]  = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h100, 8'h5A, 1'b1, 1'b0, 9'h100, 8'h5A, 1'b0, 3'd0};
        vecs[5]  = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h100, 8'h5A, 1'b0, 3'd0};
        vecs[6]  = '{1'b1, 9'h001, 8'h11, 1'b1, 9'h1AA, 8'hC3, 1'b1, 1'b1, 9'h001, 8'h11, 1'b1, 3'd1};
        vecs[7]  = '{1'b1, 9'h002, 8'h22, 1'b1, 9'h1AA, 8'hC3, 1'b1, 1'b1, 9'h002, 8'h22, 1'b1, 3'd1};
        vecs[8]  = '{1'b1, 9'h003, 8'h33, 1'b0, 9'h1AA, 8'hC3, 1'b1, 1'b1, 9'h003, 8'h33, 1'b0, 3'd1};
        vecs[9]  = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 8'h00, 1'b1, 1'b1, 9'h1AA, 8'hC3, 1'b0, 3'd0};
        vecs[10] = '{1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h1AA, 8'hC3, 1'b0, 3'd0};

        ea[0] = 9'h010; ed[0] = 8'hA0;
        ea[1] = 9'h021; ed[1] = 8'hB1;
        ea[2] = 9'h132; ed[2] = 8'hC2;
        ea[3] = 9'h1FF; ed[3] = 8'hD3;
        ea[4] = 9'h1F5; ed[4] = 8'h55;
        ecnt[0] = 3'd3; ecnt[1] = 3'd3; ecnt[2] = 3'd2; ecnt[3] = 3'd1; ecnt[4] = 3'd0;

        rst           = 1'b1;
        blank         = 1'b0;
        bus.panel_wen = 1'b0;
        bus.panel_A   = '0;
        bus.panel_D   = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_A     = '0;
        bus.cpu_D     = '0;

        // Reset state
        tick();
        tick();
        check("reset fbw_en", 32'(bus.fbw_en), 32'd0);
        check("reset fbw_A", 32'(bus.fbw_A), 32'd0);
        check("reset fbw_D", 32'(bus.fbw_D), 32'd0);
        check("reset cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset starve", 32'(starve), 32'd0);
        rst = 1'b0;

        // Panel-only, single CPU handshake, and panel/CPU collision
        for (int i = 0; i < 11; i++) begin
            bus.panel_wen = vecs[i].pw;
            bus.panel_A   = vecs[i].pa;
            bus.panel_D   = vecs[i].pd;
            bus.cpu_req   = vecs[i].req;
            bus.cpu_A     = vecs[i].ca;
            bus.cpu_D     = vecs[i].cd;
            blank         = vecs[i].blk;
            tick();
            check($sformatf("v%0d fbw_en", i), 32'(bus.fbw_en), 32'(vecs[i].e_en));
            check($sformatf("v%0d fbw_A", i), 32'(bus.fbw_A), 32'(vecs[i].e_a));
            check($sformatf("v%0d fbw_D", i), 32'(bus.fbw_D), 32'(vecs[i].e_d));
            check($sformatf("v%0d cpu_ack", i), 32'(bus.cpu_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
        end
        bus.panel_wen = 1'b0;

        // Blank-only: fill while active video, fifth request must wait
        blank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(ea[i], ed[i]);
        end
        check("blank_only count full", 32'(fifo_count), 32'd4);
        check("blank_only no write", 32'(bus.fbw_en), 32'd0);
        bus.cpu_A   = ea[4];
        bus.cpu_D   = ed[4];
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fifth req blocked ack c%0d", i), 32'(bus.cpu_ack), 32'd0);
        end
        check("fifth req count", 32'(fifo_count), 32'd4);
        check("no early starve", 32'(starve), 32'd0);

        // Blanking opens: drain in push order, fifth captured after first pop
        blank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("drain%0d fbw_en", i), 32'(bus.fbw_en), 32'd1);
            check($sformatf("drain%0d fbw_A", i), 32'(bus.fbw_A), 32'(ea[i]));
            check($sformatf("drain%0d fbw_D", i), 32'(bus.fbw_D), 32'(ed[i]));
            check($sformatf("drain%0d count", i), 32'(fifo_count), 32'(ecnt[i]));
        end
        check("fifth acked", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.cpu_ack && n < 20);
        check("fifth ack fall", 32'(bus.cpu_ack), 32'd0);

        // Starvation: full FIFO blocked by active video for 8 cycles
        blank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_write(9'(9'h040 + 9'(i)), 8'(8'h70 + 8'(i)));
        end
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("starve before limit", 32'(starve), 32'd0);
        tick();
        check("starve at limit", 32'(starve), 32'd1);
        blank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("starve drain%0d A", i), 32'(bus.fbw_A), 32'(9'h040 + 9'(i)));
        end
        tick();
        tick();
        check("starve drained count", 32'(fifo_count), 32'd0);
        check("starve sticky", 32'(starve), 32'd1);

        // Reset mid-operation with two entries queued and ack high
        blank = 1'b0;
        cpu_write(9'h0AB, 8'h01);
        bus.cpu_A   = 9'h0CD;
        bus.cpu_D   = 8'h02;
        bus.cpu_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.cpu_ack && n < 20);
        check("pre-reset ack", 32'(bus.cpu_ack), 32'd1);
        check("pre-reset count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        #1;
        check("async reset count", 32'(fifo_count), 32'd0);
        check("async reset ack", 32'(bus.cpu_ack), 32'd0);
        check("async reset fbw_en", 32'(bus.fbw_en), 32'd0);
        check("async reset starve", 32'(starve), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("recapture count", 32'(fifo_count), 32'd1);
        check("recapture ack", 32'(bus.cpu_ack), 32'd1);
        tick();
        tick();
        check("single recapture count", 32'(fifo_count), 32'd1);
        bus.cpu_req = 1'b0;
        blank       = 1'b1;
        tick();
        check("recapture ack fall", 32'(bus.cpu_ack), 32'd0);
        check("recapture write en", 32'(bus.fbw_en), 32'd1);
        check("recapture write A", 32'(bus.fbw_A), 32'h0CD);
        check("recapture write D", 32'(bus.fbw_D), 32'h02);
        check("recapture drained", 32'(fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
